// File: rtl/udp_tx_noc_arb.sv
// udp_tx_noc_arb: packet-atomic round-robin arbiter feeding the UDP TX tile NoC input
// Ports: per-source val/data in, per-source rdy out; one output flit stream (val/data out, rdy in);
// arb_grant_idx shows the current owner for debug. Optional macro UDP_TX_ARB_STATS_EN adds
// arb_stats_pkt_cnt, a 32-bit per-source count of completed packets.
module udp_tx_noc_arb #(
    parameter int NUM_SRC    = 4,
    parameter int NOC_DATA_W = 512,
    parameter int LEN_LSB    = 0,
    parameter int LEN_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_arb_noc_val,
    input  logic [NUM_SRC*NOC_DATA_W-1:0] src_arb_noc_data,
    output logic [NUM_SRC-1:0]            arb_src_noc_rdy,
    output logic                          arb_udp_tx_noc_val,
    output logic [NOC_DATA_W-1:0]         arb_udp_tx_noc_data,
    input  logic                          udp_tx_arb_noc_rdy,
    output logic [$clog2(NUM_SRC)-1:0]    arb_grant_idx
`ifdef UDP_TX_ARB_STATS_EN
    ,
    output logic [NUM_SRC*32-1:0]         arb_stats_pkt_cnt
`endif
);
    localparam int IW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  sel_val;
    logic [NOC_DATA_W-1:0] sel_data;
    logic [LEN_W-1:0]      len;
    logic [IW-1:0]         pick;
    logic                  busy;
    logic                  fire;

    always_comb begin
        sel_val  = src_arb_noc_val[grant_q];
        sel_data = src_arb_noc_data[int'(grant_q)*NOC_DATA_W +: NOC_DATA_W];
        len      = sel_data[LEN_LSB +: LEN_W];
        busy     = state_q != IDLE;
        fire     = busy & sel_val & udp_tx_arb_noc_rdy;
        // Scan downward so the valid source closest to rr_q is the last one written.
        pick = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (src_arb_noc_val[(int'(rr_q) + k) % NUM_SRC])
                pick = IW'((int'(rr_q) + k) % NUM_SRC);
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|src_arb_noc_val) begin
                grant_d = pick;
                state_d = HDR;
            end
            HDR: if (fire) begin
                cnt_d   = len;
                rr_d    = (grant_q == IW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
                state_d = (len == '0) ? IDLE : BODY;
            end
            BODY: if (fire) begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == LEN_W'(1)) ? IDLE : BODY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign arb_udp_tx_noc_val  = busy & sel_val;
    assign arb_udp_tx_noc_data = busy ? sel_data : '0;
    assign arb_src_noc_rdy     = busy ? (NUM_SRC'(udp_tx_arb_noc_rdy) << grant_q) : '0;
    assign arb_grant_idx       = grant_q;

`ifdef UDP_TX_ARB_STATS_EN
    logic                 last;
    logic [NUM_SRC*32-1:0] stats_q;

    // A zero-length packet ends on its header handshake.
    assign last = fire & (((state_q == HDR) & (len == '0)) | ((state_q == BODY) & (cnt_q == LEN_W'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stats_q <= '0;
        else if (last)
            stats_q[int'(grant_q)*32 +: 32] <= stats_q[int'(grant_q)*32 +: 32] + 32'd1;
    end

    assign arb_stats_pkt_cnt = stats_q;
`endif

endmodule
